// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single-port 8-bit data RAM between the pipeline MEM
//            stage and a loader/debug port. One RAM transaction at a time,
//            waits out the RAM read latency, returns read data, stalls the
//            pipeline while a MEM-stage access is pending, and forces a
//            waiting loader ahead after MAX_WAIT consecutive CPU grants.
// Params   : RAM_LAT  (1..3)  cycles from ram_en until ram_rdata is valid
//            MAX_WAIT (1..15) CPU grants tolerated before loader preemption
// Ports    : clk, rst_n              clock, async active-low reset
//            i_cpu_read/write/addr/wdata, o_cpu_rdata, o_cpu_stall   MEM stage
//            i_ldr_req/we/addr/wdata, o_ldr_gnt/done/rdata           loader
//            o_ram_en/we/addr/wdata, i_ram_rdata                     RAM side
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cpu_read,
  input  logic       i_cpu_write,
  input  logic [7:0] i_cpu_addr,
  input  logic [7:0] i_cpu_wdata,
  output logic [7:0] o_cpu_rdata,
  output logic       o_cpu_stall,
  input  logic       i_ldr_req,
  input  logic       i_ldr_we,
  input  logic [7:0] i_ldr_addr,
  input  logic [7:0] i_ldr_wdata,
  output logic       o_ldr_gnt,
  output logic       o_ldr_done,
  output logic [7:0] o_ldr_rdata,
  output logic       o_ram_en,
  output logic       o_ram_we,
  output logic [7:0] o_ram_addr,
  output logic [7:0] o_ram_wdata,
  input  logic [7:0] i_ram_rdata
);

  localparam logic [0:0] c_ST_IDLE    = 1'b0;
  localparam logic [0:0] c_ST_ACCESS  = 1'b1;
  localparam logic       c_OWN_CPU    = 1'b0;
  localparam logic       c_OWN_LDR    = 1'b1;
  localparam logic [1:0] c_CNT_INIT   = 2'(RAM_LAT);
  localparam logic [3:0] c_STARVE_MAX = 4'(MAX_WAIT);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       r_owner;
  logic       r_acc_we;      // whole-transaction write flag (ram_we is only a pulse)
  logic [1:0] r_cnt;
  logic [3:0] r_starve;
  logic       r_cpu_done;
  logic       r_ldr_done;
  logic       r_ram_en;
  logic       r_ram_we;
  logic [7:0] r_ram_addr;
  logic [7:0] r_ram_wdata;
  logic [7:0] r_cpu_rdata;
  logic [7:0] r_ldr_rdata;

  logic w_cpu_req;
  logic w_cpu_live;
  logic w_ldr_live;
  logic w_starved;
  logic w_complete;
  logic w_gnt_cpu;
  logic w_gnt_ldr;

  assign w_cpu_req  = i_cpu_read | i_cpu_write;
  // A request whose completion pulse is showing is the one just served.
  assign w_cpu_live = w_cpu_req & ~r_cpu_done;
  assign w_ldr_live = i_ldr_req & ~r_ldr_done;
  assign w_starved  = (r_starve == c_STARVE_MAX);
  assign w_complete = (r_state == c_ST_ACCESS) && (r_cnt == 2'd1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and grant decision
  // The loader only gets in ahead of the CPU when starved, or when the MEM
  // stage has no strobe raised at all. The raw CPU strobe is used here so a
  // CPU sitting in its done cycle still holds the loader off; otherwise the
  // loader would slip in after every CPU access and starvation never counts.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_cpu   = 1'b0;
    w_gnt_ldr   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_ldr_live && (w_starved || !w_cpu_req)) begin
          w_gnt_ldr = 1'b1;
        end else if (w_cpu_live) begin
          w_gnt_cpu = 1'b1;
        end
        if (w_gnt_ldr || w_gnt_cpu) begin
          w_state_nxt = c_ST_ACCESS;
        end
      end
      c_ST_ACCESS: begin
        if (r_cnt == 2'd1) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // Stall is qualified by rst_n so every output reads 0 while reset is held.
  // --------------------------------------------------------------------------
  always_comb begin
    o_cpu_stall = w_cpu_req & ~r_cpu_done & rst_n;
    o_ldr_gnt   = (r_state == c_ST_ACCESS) && (r_owner == c_OWN_LDR);
  end

  // --------------------------------------------------------------------------
  // Transaction datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= c_OWN_CPU;
      r_acc_we    <= 1'b0;
      r_cnt       <= 2'd0;
      r_cpu_done  <= 1'b0;
      r_ldr_done  <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 8'h00;
      r_ram_wdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_ldr_rdata <= 8'h00;
    end else begin
      r_cpu_done <= 1'b0;
      r_ldr_done <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      if (w_gnt_cpu) begin
        r_owner     <= c_OWN_CPU;
        r_acc_we    <= i_cpu_write;
        r_ram_en    <= 1'b1;
        r_ram_we    <= i_cpu_write;
        r_ram_addr  <= i_cpu_addr;
        r_ram_wdata <= i_cpu_wdata;
        r_cnt       <= c_CNT_INIT;
      end else if (w_gnt_ldr) begin
        r_owner     <= c_OWN_LDR;
        r_acc_we    <= i_ldr_we;
        r_ram_en    <= 1'b1;
        r_ram_we    <= i_ldr_we;
        r_ram_addr  <= i_ldr_addr;
        r_ram_wdata <= i_ldr_wdata;
        r_cnt       <= c_CNT_INIT;
      end else if (r_state == c_ST_ACCESS) begin
        r_cnt <= r_cnt - 2'd1;
        if (w_complete) begin
          if (r_owner == c_OWN_LDR) begin
            r_ldr_done <= 1'b1;
            if (!r_acc_we) begin
              r_ldr_rdata <= i_ram_rdata;
            end
          end else begin
            r_cpu_done <= 1'b1;
            if (!r_acc_we) begin
              r_cpu_rdata <= i_ram_rdata;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Loader starvation counter, saturating at MAX_WAIT
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (!i_ldr_req || w_gnt_ldr) begin
      r_starve <= 4'd0;
    end else if (w_gnt_cpu && (r_starve < c_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_ldr_done  = r_ldr_done;
  assign o_ldr_rdata = r_ldr_rdata;
  assign o_ram_en    = r_ram_en;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-port 8-bit data RAM. It shares the RAM between the pipeline's MEM stage (read/write strobes, ALU-computed address, store data) and a loader/debug port. It issues one RAM transaction at a time, waits out the RAM read latency, and returns read data. It stalls the pipeline while a MEM-stage access is pending. The loader is guaranteed service within a bounded number of CPU accesses.

## Interface
Parameters:
- RAM_LAT, 1: cycles from the ram_en cycle until ram_rdata is valid; legal range 1..3.
- MAX_WAIT, 4: number of consecutive CPU grants after which a pending loader request is forced ahead; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_read  in  1  MEM-stage load request (level).
- cpu_write  in  1  MEM-stage store request (level).
- cpu_addr  in  8  MEM-stage RAM address.
- cpu_wdata  in  8  MEM-stage store data.
- cpu_rdata  out  8  last CPU load result.
- cpu_stall  out  1  freeze request to the pipeline.
- ldr_req  in  1  loader request (level, held until ldr_done).
- ldr_we  in  1  loader write (1) / read (0).
- ldr_addr  in  8  loader address.
- ldr_wdata  in  8  loader write data.
- ldr_gnt  out  1  loader transaction in flight.
- ldr_done  out  1  one-cycle loader completion pulse.
- ldr_rdata  out  8  last loader read result.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  8  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data.

## Operation
- cpu_req = cpu_read | cpu_write. If both strobes are high, the access is a write.
- The FSM has two states: IDLE and ACCESS. An owner register records CPU or LDR.
- IDLE: requests are sampled at each edge.
  - A request whose done pulse is high in the current cycle is ignored. This prevents re-granting a completed request.
  - Default priority: CPU.
  - The loader wins instead when ldr_req is high and starve == MAX_WAIT.
  - On a grant: ram_en, ram_we, ram_addr and ram_wdata are registered from the winner, cnt is set to RAM_LAT, and the FSM moves to ACCESS.
- ACCESS:
  - ram_en and ram_we are held high for only the first cycle of ACCESS; ram_addr and ram_wdata hold their values.
  - cnt decrements every edge.
  - The edge where cnt == 1 is the completion edge:
    - For a read, ram_rdata is captured into the owner's rdata register.
    - The owner's done flag is set for one cycle (cpu_done is internal; ldr_done is the port).
    - The FSM returns to IDLE.
- Starve counter (4 bits, saturating at MAX_WAIT):
  - Increments on each CPU grant while ldr_req is high.
  - Clears on a loader grant, or whenever ldr_req is low.
- Output behaviour:
  - cpu_stall = cpu_req & ~cpu_done (combinational).
  - ldr_gnt is high whenever the FSM is in ACCESS with owner LDR.
  - cpu_rdata and ldr_rdata hold their values until the next read by the same owner. Writes never change them.

## Timing
- Reset value of every output is 0. State resets to IDLE, starve to 0, cnt to 0.
- Reset asserted mid-ACCESS aborts the transaction immediately (asynchronously):
  - ram_en drops to 0.
  - No done pulse is generated.
  - No rdata update occurs.
- Per-access timing:
  - Grant edge k; ram_en is high during cycle k..k+1.
  - Completion edge is k+RAM_LAT; the done flag is high during cycle k+RAM_LAT..k+RAM_LAT+1.
  - The earliest next grant is at edge k+RAM_LAT+1.
  - Throughput: one access per RAM_LAT+1 cycles.
- CPU load latency:
  - With the request present at edge k, cpu_stall is high for RAM_LAT cycles, then low in the done cycle.
  - cpu_rdata is valid in the done cycle.
  - If the loader owns the RAM, the stall extends by that loader access plus one cycle.
- Loader handshake: the loader must drop ldr_req, or present a new request, during the ldr_done cycle. The arbiter ignores ldr_req in that cycle.
- Loader worst-case wait under continuous CPU traffic: MAX_WAIT CPU accesses plus the in-flight access.
- ram_rdata is sampled only on the completion edge of a read.

## Test plan
- Reset: drive rst_n=0 with random inputs -> every output is 0. Release reset with no requests -> ram_en stays 0.
- CPU read, RAM_LAT=1, RAM[0x20]=0x5A: assert cpu_read with cpu_addr=0x20 -> ram_en pulses for one cycle with ram_addr=0x20 and ram_we=0; cpu_stall is high for 1 cycle; cpu_rdata=0x5A in the done cycle while stall is 0.
- Loader write then CPU read: ldr_we=1, ldr_addr=0x80, ldr_wdata=0x33 -> ram_we pulse and ldr_done pulse. Then cpu_read at 0x80 -> cpu_rdata=0x33; ldr_rdata is unchanged.
- Contention, MAX_WAIT=4: hold cpu_read and ldr_req continuously -> grants go CPU×4, then LDR, then CPU×4 again.
- Reset mid-ACCESS, RAM_LAT=3: assert rst_n=0 one cycle after the grant -> ram_en=0 immediately, no done pulse. A fresh cpu_read after release completes in 3 cycles.
- cpu_read=cpu_write=1, cpu_wdata=0xC7 -> ram_we=1 with ram_wdata=0xC7; cpu_rdata is unchanged.
